// File: rtl/qtree_bool_serializer_pkg.sv
// Shared types for the QTree_Bool serializer: tag encoding, node word layout,
// traversal stack entry and FSM state encoding.
package qtree_bool_ser_package;

    localparam int QT_ADDR_W = 16;
    localparam int QT_NODE_W = 2 + 4 * QT_ADDR_W;
    localparam int QT_IDX_W  = 3;

    typedef logic [1:0]           tag_t;
    typedef logic [QT_ADDR_W-1:0] addr_t;
    typedef logic [QT_NODE_W-1:0] node_t;

    localparam tag_t TAG_QNONE  = 2'd0;
    localparam tag_t TAG_QVAL   = 2'd1;
    localparam tag_t TAG_QNODE  = 2'd2;
    localparam tag_t TAG_QERROR = 2'd3;

    // idx counts children already visited; it reaches 4 once all are done.
    typedef struct packed {
        node_t                word;
        logic [QT_IDX_W-1:0]  idx;
    } stack_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        EMIT,
        ADVANCE
    } ser_state_t;

    function automatic tag_t nodeTag(input node_t w);
        return w[1:0];
    endfunction

    function automatic addr_t childPtr(input node_t w, input logic [1:0] k);
        return w[2 + QT_ADDR_W * k +: QT_ADDR_W];
    endfunction

    // A parent beat carries only its tag; pointers are meaningless downstream.
    function automatic node_t zeroChildren(input node_t w);
        node_t z;
        z      = '0;
        z[1:0] = w[1:0];
        return z;
    endfunction

endpackage

// File: rtl/qtree_bool_serializer_stack.sv
// Traversal LIFO of QNode ancestors. Storage is registered; the top entry is
// visible combinationally so the FSM can act on it in the same cycle.
module qtree_ser_stack
    import qtree_bool_ser_package::*;
#(
    parameter  int DEPTH = 16,
    localparam int SP_W  = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  stack_entry_t pushEntry,
    input  logic         pop,
    input  logic         updTop,
    input  stack_entry_t updEntry,
    output stack_entry_t top,
    output logic [SP_W-1:0] count,
    output logic         full,
    output logic         empty
);

    stack_entry_t    mem [DEPTH];
    logic [SP_W-1:0] spReg;
    logic [IDX_W-1:0] topIdx;

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && !full && spReg == SP_W'(i)) begin
                mem[i] <= pushEntry;
            end else if (updTop && spReg == SP_W'(i + 1)) begin
                mem[i] <= updEntry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            spReg <= '0;
        end else if (push && !full) begin
            spReg <= spReg + SP_W'(1);
        end else if (pop && !empty) begin
            spReg <= spReg - SP_W'(1);
        end
    end

    assign full   = (spReg == SP_W'(DEPTH));
    assign empty  = (spReg == '0);
    assign count  = spReg;
    assign topIdx = empty ? '0 : IDX_W'(spReg - SP_W'(1));
    assign top    = mem[topIdx];

endmodule

// File: rtl/qtree_bool_serializer.sv
// Post-order serializer: walks a heap-resident QTree_Bool from a root pointer
// and streams every node word, children 0..3 before their parent.
module qtree_bool_serializer
    import qtree_bool_ser_package::*;
#(
    parameter int ADDR_W    = QT_ADDR_W,
    parameter int NODE_W    = QT_NODE_W,
    parameter int MAX_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] root_data,
    input  logic              root_valid,
    output logic              root_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_addr_valid,
    input  logic              rd_addr_ready,
    input  logic [NODE_W-1:0] rd_data,
    input  logic              rd_data_valid,
    output logic              rd_data_ready,
    output logic [NODE_W-1:0] o_tdata,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic              o_tlast,
    output logic              busy,
    output logic              overflow
);

    localparam int SP_W = $clog2(MAX_DEPTH + 1);

    ser_state_t          stateReg, stateNext;
    logic [ADDR_W-1:0]   rdAddrReg, rdAddrNext;
    logic [NODE_W-1:0]   tdataReg, tdataNext;
    logic                tlastReg, tlastNext;
    logic                overflowReg, overflowNext;
    logic                rootReadyReg, rdAddrValidReg, rdDataReadyReg;
    logic                tvalidReg, busyReg;

    stack_entry_t        pushEntry, updEntry, topEntry;
    logic                stkPush, stkPop, stkUpd, stkClear;
    logic                stkFull, stkEmpty;
    logic [SP_W-1:0]     stkCount;
    logic [QT_IDX_W-1:0] nextIdx;
    node_t               respWord;

    assign respWord = rd_data;

    qtree_ser_stack #(
        .DEPTH(MAX_DEPTH)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .clear    (stkClear),
        .push     (stkPush),
        .pushEntry(pushEntry),
        .pop      (stkPop),
        .updTop   (stkUpd),
        .updEntry (updEntry),
        .top      (topEntry),
        .count    (stkCount),
        .full     (stkFull),
        .empty    (stkEmpty)
    );

    always_comb begin
        stateNext      = stateReg;
        rdAddrNext     = rdAddrReg;
        tdataNext      = tdataReg;
        tlastNext      = 1'b0;
        overflowNext   = overflowReg;
        stkPush        = 1'b0;
        stkPop         = 1'b0;
        stkUpd         = 1'b0;
        stkClear       = 1'b0;
        pushEntry.word = respWord;
        pushEntry.idx  = '0;
        nextIdx        = topEntry.idx + QT_IDX_W'(1);
        updEntry       = topEntry;
        updEntry.idx   = nextIdx;

        case (stateReg)
            IDLE: begin
                if (root_valid && rootReadyReg) begin
                    rdAddrNext = root_data;
                    stateNext  = REQ;
                end
            end
            REQ: begin
                if (rd_addr_ready) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                if (rd_data_valid) begin
                    if (nodeTag(respWord) == TAG_QNODE) begin
                        if (stkFull) begin
                            // Tree deeper than the stack: abandon it without a tlast.
                            overflowNext = 1'b1;
                            stkClear     = 1'b1;
                            stateNext    = IDLE;
                        end else begin
                            stkPush    = 1'b1;
                            rdAddrNext = childPtr(respWord, 2'd0);
                            stateNext  = REQ;
                        end
                    end else begin
                        tdataNext = rd_data;
                        tlastNext = stkEmpty;
                        stateNext = EMIT;
                    end
                end
            end
            EMIT: begin
                tlastNext = tlastReg;
                if (o_tready) begin
                    tlastNext = 1'b0;
                    stateNext = stkEmpty ? IDLE : ADVANCE;
                end
            end
            ADVANCE: begin
                if (nextIdx < QT_IDX_W'(4)) begin
                    stkUpd     = 1'b1;
                    rdAddrNext = childPtr(topEntry.word, nextIdx[1:0]);
                    stateNext  = REQ;
                end else begin
                    stkPop    = 1'b1;
                    tdataNext = zeroChildren(topEntry.word);
                    tlastNext = (stkCount == SP_W'(1));
                    stateNext = EMIT;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Handshake outputs are decoded from the next state so they are true flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg       <= IDLE;
            rdAddrReg      <= '0;
            tdataReg       <= '0;
            tlastReg       <= 1'b0;
            overflowReg    <= 1'b0;
            rootReadyReg   <= 1'b1;
            rdAddrValidReg <= 1'b0;
            rdDataReadyReg <= 1'b0;
            tvalidReg      <= 1'b0;
            busyReg        <= 1'b0;
        end else begin
            stateReg       <= stateNext;
            rdAddrReg      <= rdAddrNext;
            tdataReg       <= tdataNext;
            tlastReg       <= tlastNext;
            overflowReg    <= overflowNext;
            rootReadyReg   <= (stateNext == IDLE);
            rdAddrValidReg <= (stateNext == REQ);
            rdDataReadyReg <= (stateNext == RESP);
            tvalidReg      <= (stateNext == EMIT);
            busyReg        <= (stateNext != IDLE);
        end
    end

    assign root_ready    = rootReadyReg;
    assign rd_addr       = rdAddrReg;
    assign rd_addr_valid = rdAddrValidReg;
    assign rd_data_ready = rdDataReadyReg;
    assign o_tdata       = tdataReg;
    assign o_tvalid      = tvalidReg;
    assign o_tlast       = tlastReg;
    assign busy          = busyReg;
    assign overflow      = overflowReg;

endmodule

// File: tb/tb_qtree_bool_serializer.sv
// Scoreboard bench for qtree_bool_serializer: heap model, expected-read and
// expected-beat queues, and a monitor that checks beats and stall stability.
module tb_qtree_bool_serializer;

    typedef struct {
        logic [65:0] data;
        logic        last;
    } beat_t;

    logic        clk;
    logic        reset;
    logic [15:0] root_data;
    logic        root_valid;
    logic        root_ready;
    logic [15:0] rd_addr;
    logic        rd_addr_valid;
    logic        rd_addr_ready;
    logic [65:0] rd_data;
    logic        rd_data_valid;
    logic        rd_data_ready;
    logic [65:0] o_tdata;
    logic        o_tvalid;
    logic        o_tready;
    logic        o_tlast;
    logic        busy;
    logic        overflow;

    int          checks    = 0;
    int          failures  = 0;
    int          beatsSeen = 0;
    int          stallAt   = -1;
    bit          toggleMode = 0;
    bit          slowMode   = 0;
    int          delays [6] = '{0, 3, 1, 5, 2, 4};

    logic [65:0] heap [int];
    beat_t       expQ [$];
    logic [15:0] expReads [$];

    qtree_bool_serializer #(
        .ADDR_W   (16),
        .NODE_W   (66),
        .MAX_DEPTH(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .root_data    (root_data),
        .root_valid   (root_valid),
        .root_ready   (root_ready),
        .rd_addr      (rd_addr),
        .rd_addr_valid(rd_addr_valid),
        .rd_addr_ready(rd_addr_ready),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .rd_data_ready(rd_data_ready),
        .o_tdata      (o_tdata),
        .o_tvalid     (o_tvalid),
        .o_tready     (o_tready),
        .o_tlast      (o_tlast),
        .busy         (busy),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end else begin
            $display("ok   %s value=%0h t=%0t", nm, act, $time);
        end
    endtask

    task automatic failNow(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timed out t=%0t", nm, $time);
    endtask

    function automatic logic [65:0] mkNode(input logic [15:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0, 2'b10};
    endfunction

    task automatic expectBeat(input logic [65:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        expQ.push_back(b);
    endtask

    task automatic issueRoot(input logic [15:0] a);
        bit ok;
        ok         = 0;
        root_data  = a;
        root_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (root_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        root_valid = 1'b0;
        if (!ok) failNow("root_accept");
        chk("busy_after_root", busy, 1'b1);
        chk("root_ready_while_busy", root_ready, 1'b0);
    endtask

    task automatic waitDone(input string nm, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (expQ.size() == 0 && expReads.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) failNow(nm);
        chk({nm, "_busy_done"}, busy, 1'b0);
        chk({nm, "_root_ready_done"}, root_ready, 1'b1);
    endtask

    task automatic checkResetState(input string nm);
        chk({nm, "_ctrl"}, {root_ready, rd_addr_valid, rd_data_ready, o_tvalid, o_tlast, busy, overflow},
            7'b1000000);
        chk({nm, "_tdata"}, o_tdata, 66'h0);
        chk({nm, "_rd_addr"}, rd_addr, 16'h0);
    endtask

    task automatic loadTree2();
        expReads.push_back(16'h0100);
        expReads.push_back(16'h0020);
        expReads.push_back(16'h0030);
        expReads.push_back(16'h0040);
        expReads.push_back(16'h0050);
        expectBeat(66'h5, 1'b0);
        expectBeat(66'h1, 1'b0);
        expectBeat(66'h1, 1'b0);
        expectBeat(66'h5, 1'b0);
        expectBeat(66'h2, 1'b1);
    endtask

    task automatic loadTree3();
        expReads.push_back(16'h0200);
        expReads.push_back(16'h0210);
        expReads.push_back(16'h0220);
        expReads.push_back(16'h0300);
        expReads.push_back(16'h0310);
        expReads.push_back(16'h0320);
        expReads.push_back(16'h0330);
        expReads.push_back(16'h0230);
        expReads.push_back(16'h0240);
        expectBeat(66'h5, 1'b0);
        expectBeat(66'h1, 1'b0);
        expectBeat(66'h5, 1'b0);
        expectBeat(66'h2_DEAD_BEEF_1234_5673, 1'b0);
        expectBeat(66'h0, 1'b0);
        expectBeat(66'h2, 1'b0);
        expectBeat(66'h1_0000_0000_0000_0000, 1'b0);
        expectBeat(66'h3, 1'b0);
        expectBeat(66'h2, 1'b1);
    endtask

    // Heap: accepts one request at a time, answers after a configurable delay.
    initial begin : heapModel
        int          waitCnt;
        int          dlyIdx;
        bit          pending;
        bit          addrXfer;
        bit          dataXfer;
        logic [15:0] pendAddr;
        logic [15:0] want;
        waitCnt       = 0;
        dlyIdx        = 0;
        pending       = 0;
        addrXfer      = 0;
        dataXfer      = 0;
        pendAddr      = '0;
        rd_addr_ready = 1'b0;
        rd_data_valid = 1'b0;
        rd_data       = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pending       = 0;
                rd_addr_ready = 1'b0;
                rd_data_valid = 1'b0;
            end else begin
                if (dataXfer) begin
                    rd_data_valid = 1'b0;
                    pending       = 0;
                end
                if (addrXfer) begin
                    pending       = 1;
                    rd_addr_ready = 1'b0;
                    waitCnt       = slowMode ? delays[dlyIdx] : 0;
                    dlyIdx        = (dlyIdx + 1) % 6;
                end
                if (pending && !rd_data_valid) begin
                    if (waitCnt == 0) begin
                        rd_data_valid = 1'b1;
                        rd_data       = heap[int'(pendAddr)];
                    end else begin
                        waitCnt--;
                    end
                end
                if (!pending) rd_addr_ready = 1'b1;
            end
            addrXfer = !reset && rd_addr_valid && rd_addr_ready;
            dataXfer = !reset && rd_data_valid && rd_data_ready;
            if (addrXfer) begin
                pendAddr = rd_addr;
                if (expReads.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read addr=%h expected=none", rd_addr);
                end else begin
                    want = expReads.pop_front();
                    chk("read_addr", rd_addr, want);
                end
            end
        end
    end

    initial begin : treadyDriver
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stallAt >= 0 && beatsSeen >= stallAt) o_tready = 1'b0;
            else if (toggleMode)                      o_tready = ~o_tready;
            else                                      o_tready = 1'b1;
        end
    end

    initial begin : monitor
        bit          prevStall;
        logic [65:0] prevData;
        logic        prevLast;
        beat_t       b;
        prevStall = 0;
        prevData  = '0;
        prevLast  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevStall = 0;
            end else begin
                if (prevStall) begin
                    chk("stall_tvalid", o_tvalid, 1'b1);
                    chk("stall_tdata", o_tdata, prevData);
                    chk("stall_tlast", o_tlast, prevLast);
                end
                if (o_tvalid && o_tready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat got=%h last=%b expected=none", o_tdata, o_tlast);
                    end else begin
                        b = expQ.pop_front();
                        chk($sformatf("beat%0d_tdata", beatsSeen), o_tdata, b.data);
                        chk($sformatf("beat%0d_tlast", beatsSeen), o_tlast, b.last);
                    end
                    beatsSeen++;
                end
                prevStall = o_tvalid && !o_tready;
                prevData  = o_tdata;
                prevLast  = o_tlast;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit ok;
        reset      = 1'b1;
        root_valid = 1'b0;
        root_data  = '0;

        heap[32'h0010] = 66'h5;
        heap[32'h0100] = mkNode(16'h0020, 16'h0030, 16'h0040, 16'h0050);
        heap[32'h0020] = 66'h5;
        heap[32'h0030] = 66'h1;
        heap[32'h0040] = 66'h1;
        heap[32'h0050] = 66'h5;
        heap[32'h0200] = mkNode(16'h0210, 16'h0220, 16'h0230, 16'h0240);
        heap[32'h0210] = 66'h5;
        heap[32'h0220] = mkNode(16'h0300, 16'h0310, 16'h0320, 16'h0330);
        heap[32'h0230] = 66'h1_0000_0000_0000_0000;
        heap[32'h0240] = 66'h3;
        heap[32'h0300] = 66'h1;
        heap[32'h0310] = 66'h5;
        heap[32'h0320] = 66'h2_DEAD_BEEF_1234_5673;
        heap[32'h0330] = 66'h0;
        heap[32'h0400] = mkNode(16'h0410, 16'h0, 16'h0, 16'h0);
        heap[32'h0410] = mkNode(16'h0420, 16'h0, 16'h0, 16'h0);
        heap[32'h0420] = mkNode(16'h0430, 16'h0, 16'h0, 16'h0);

        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single QVal leaf
        expReads.push_back(16'h0010);
        expectBeat(66'h5, 1'b1);
        issueRoot(16'h0010);
        waitDone("leaf", 200);

        // QNode with four leaf children
        loadTree2();
        issueRoot(16'h0100);
        waitDone("node4", 400);

        // Depth-2 tree, child1 is a QNode (fills the 2-entry stack exactly)
        loadTree3();
        issueRoot(16'h0200);
        waitDone("depth2", 600);

        // Same tree with toggling backpressure and variable heap latency
        toggleMode = 1;
        slowMode   = 1;
        loadTree3();
        issueRoot(16'h0200);
        waitDone("depth2_bp", 2000);
        toggleMode = 0;
        slowMode   = 0;

        // 3-deep QNode chain overflows a 2-entry stack
        expReads.push_back(16'h0400);
        expReads.push_back(16'h0410);
        expReads.push_back(16'h0420);
        issueRoot(16'h0400);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (overflow) begin
                ok = 1;
                break;
            end
        end
        if (!ok) failNow("overflow_wait");
        chk("overflow_set", overflow, 1'b1);
        chk("overflow_idle_busy", busy, 1'b0);
        chk("overflow_root_ready", root_ready, 1'b1);
        chk("overflow_no_tvalid", o_tvalid, 1'b0);
        chk("overflow_reads_done", expReads.size(), 0);

        expReads.push_back(16'h0010);
        expectBeat(66'h5, 1'b1);
        issueRoot(16'h0010);
        waitDone("leaf_after_ovf", 200);
        chk("overflow_sticky", overflow, 1'b1);

        // Reset while the third beat is stalled in EMIT
        stallAt = beatsSeen + 2;
        loadTree2();
        issueRoot(16'h0100);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (o_tvalid && beatsSeen == stallAt) begin
                ok = 1;
                break;
            end
        end
        if (!ok) failNow("third_beat_wait");
        chk("third_beat_tdata", o_tdata, 66'h1);
        reset = 1'b1;
        expQ.delete();
        expReads.delete();
        @(posedge clk);
        #1;
        checkResetState("midreset");
        reset   = 1'b0;
        stallAt = -1;
        @(posedge clk);
        #1;

        expReads.push_back(16'h0010);
        expectBeat(66'h5, 1'b1);
        issueRoot(16'h0010);
        waitDone("leaf_after_reset", 200);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qtree_bool_serializer.md
Name: qtree_bool_serializer

Overview:
- Transmit-side counterpart of the QTree_Bool stream deserializer.
- Accepts a root pointer, walks the heap-resident QTree_Bool by reading node words through a handshaked read port, and emits nodes as an AXI-stream in post-order (children 0..3, then parent). The deserializer rebuilds the tree from this order.
- Sits between the kernel result buffer and the output DMA/host stream.

Parameters:
ADDR_W, 16, heap pointer width.
NODE_W, 66, node word width; must equal 2+4*ADDR_W.
MAX_DEPTH, 16, traversal stack entries, i.e. the maximum number of QNode ancestors.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
root_data  in  ADDR_W  root pointer of the tree to serialize
root_valid  in  1  root pointer valid
root_ready  out  1  serializer idle; accepts a root
rd_addr  out  ADDR_W  heap read address
rd_addr_valid  out  1  read request valid
rd_addr_ready  in  1  heap accepts request
rd_data  in  NODE_W  node word returned by heap
rd_data_valid  in  1  read data valid
rd_data_ready  out  1  serializer accepts read data
o_tdata  out  NODE_W  emitted node word
o_tvalid  out  1  stream valid
o_tready  in  1  stream ready
o_tlast  out  1  last beat of the tree (root node)
busy  out  1  traversal in progress
overflow  out  1  sticky; stack overflow occurred

Behaviour:
- Node word format:
  - [1:0] tag: 0 QNone, 1 QVal, 2 QNode, 3 QError.
  - QVal: Bool payload in [2].
  - QNode: child k pointer in [2+ADDR_W*k +: ADDR_W], k=0..3.
- Handshake rule: transfer occurs when valid&&ready on a rising edge. All outputs are registered.
- Reset values: root_ready=1, rd_addr_valid=0, rd_data_ready=0, o_tvalid=0, o_tlast=0, o_tdata=0, rd_addr=0, busy=0, overflow=0. Stack pointer is 0 and the FSM is in IDLE.
- FSM states: IDLE, REQ, RESP, EMIT, ADVANCE.
- IDLE: root_ready=1. On a root transfer, load rd_addr=root_data and go to REQ. busy=1 from the next cycle.
- REQ: rd_addr_valid=1 until rd_addr_ready, then go to RESP.
- RESP: rd_data_ready=1. On rd_data transfer:
  - Tag QNode:
    - If sp==MAX_DEPTH: set overflow, clear the stack, go to IDLE. No beat is emitted and o_tlast is not issued.
    - Otherwise push {word, idx=0}, set rd_addr=child0, go to REQ.
  - Any other tag: load o_tdata=word and go to EMIT.
- EMIT: o_tvalid=1; o_tlast=1 iff sp==0 (root beat). o_tdata is held stable until o_tready. On transfer:
  - If sp==0, go to IDLE (busy=0, root_ready=1 the next cycle).
  - Otherwise go to ADVANCE.
- ADVANCE: increment idx of the top entry.
  - If idx<4: rd_addr=child[idx] of the top entry, go to REQ.
  - If idx==4: pop, and load o_tdata = top word with all child-pointer fields zeroed (tag kept). Go to EMIT.
- Minimum cost per node: 3 cycles for a leaf (REQ, RESP, EMIT), plus 1 ADVANCE cycle per child return. No combinational paths input to output.
- Stack depth is exactly MAX_DEPTH. With sp==MAX_DEPTH-1 a push succeeds; only the push at sp==MAX_DEPTH overflows.
- overflow clears only on reset. After an overflow the block accepts new roots.
- QError and QNone are emitted as leaves unchanged.
- root_valid while busy: root_ready=0; the root is held off (no queuing).
- Reset mid-operation: everything returns to reset values the next cycle. Outstanding heap reads are abandoned; the heap must tolerate a dropped response.
- Throughput: one tree in flight. Consecutive trees are separated by at least 1 IDLE cycle.

Decomposition:
- Package qtree_bool_ser_package:
  - tag constants (QNone, QVal, QNode, QError);
  - node word typedef and child-field extraction/zeroing functions;
  - stack entry typedef {node word, 3-bit idx}.
- One sub-module, qtree_ser_stack: a MAX_DEPTH-entry LIFO with push, pop, top-update of idx, and full/empty flags. It is registered, and top is readable the same cycle.

Test Plan:
- Single leaf: root 0x0010 → QVal true (tag 1, bit2=1) → exactly one beat, tdata[1:0]=1, tdata[2]=1, tlast=1. Next cycle busy=0, root_ready=1.
- One QNode with 4 QVal children at 0x20, 0x30, 0x40, 0x50 → reads in order root, 0x20, 0x30, 0x40, 0x50 → 5 beats: 4 leaves in child order, then tag 2 with zeroed children and tlast=1 on the fifth beat only.
- Depth-2 tree, child1 itself a QNode → 9 beats in post-order. Loopback through the deserializer reproduces an identical tree.
- Backpressure: o_tready toggled 1010…, heap responses delayed 0–5 cycles → same beat sequence, o_tdata/o_tlast stable while stalled.
- MAX_DEPTH=2 with a 3-deep QNode chain → overflow=1, no tlast, returns to IDLE. A following single-leaf root serializes correctly.
- Reset asserted while in EMIT on the third beat → next cycle all outputs at reset values. A new root then serializes from scratch.
